// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port memory between an instruction-fetch
// port and a data read/write port. Three-state FSM (IDLE -> ISSUE -> RESP).
// Memory-side outputs are registered: they are loaded on the IDLE->ISSUE
// edge, held through ISSUE and RESP (including wait states), and the strobes
// drop on the completing edge.
// Optional feature: define ARB_ROUND_ROBIN_EN to alternate grants between the
// ports on simultaneous requests; otherwise the data port always wins.
module mem_arbiter #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
) (
  input  logic              clock,
  input  logic              reset,
  // instruction-fetch port
  input  logic              instr_rd,
  input  logic [ADDR_W-1:0] pc,
  output logic [DATA_W-1:0] Instr_dout,
  output logic              complete_instr,
  // data port
  input  logic              Data_rd,
  input  logic              Data_wr,
  input  logic [ADDR_W-1:0] Data_addr,
  input  logic [DATA_W-1:0] Data_din,
  output logic [DATA_W-1:0] Data_dout,
  output logic              complete_data,
  // shared memory
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_din,
  output logic              mem_rd,
  output logic              mem_wr,
  input  logic [DATA_W-1:0] mem_dout,
  input  logic              mem_complete,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  state_t            state_reg, state_next;
  logic              sel_reg, sel_next;           // owner: 0 = instr, 1 = data
  logic              lg_reg, lg_next;             // last port granted
  logic [ADDR_W-1:0] mem_addr_reg, mem_addr_next;
  logic [DATA_W-1:0] mem_din_reg, mem_din_next;
  logic              mem_rd_reg, mem_rd_next;
  logic              mem_wr_reg, mem_wr_next;
  logic [DATA_W-1:0] instr_dout_reg, instr_dout_next;
  logic [DATA_W-1:0] data_dout_reg, data_dout_next;
  logic              complete_instr_reg, complete_instr_next;
  logic              complete_data_reg, complete_data_next;

  logic data_req;
  logic grant_data;

  assign data_req = Data_rd | Data_wr;

  // Port selection for a new access; only meaningful while IDLE.
  always_comb begin
    grant_data = data_req;
    if (instr_rd && data_req) begin
`ifdef ARB_ROUND_ROBIN_EN
      grant_data = ~lg_reg;
`else
      grant_data = 1'b1;
`endif
    end
  end

  // Next-state and next-output logic for the access sequencer.
  always_comb begin
    state_next          = state_reg;
    sel_next            = sel_reg;
    lg_next             = lg_reg;
    mem_addr_next       = mem_addr_reg;
    mem_din_next        = mem_din_reg;
    mem_rd_next         = mem_rd_reg;
    mem_wr_next         = mem_wr_reg;
    instr_dout_next     = instr_dout_reg;
    data_dout_next      = data_dout_reg;
    complete_instr_next = 1'b0;
    complete_data_next  = 1'b0;

    case (state_reg)
      IDLE: begin
        mem_rd_next = 1'b0;
        mem_wr_next = 1'b0;
        if (instr_rd || data_req) begin
          state_next = ISSUE;
          sel_next   = grant_data;
          if (grant_data) begin
            mem_addr_next = Data_addr;
            mem_din_next  = Data_din;
            // A simultaneous read and write request is serviced as a read.
            mem_rd_next   = Data_rd;
            mem_wr_next   = Data_wr & ~Data_rd;
          end else begin
            mem_addr_next = pc;
            mem_rd_next   = 1'b1;
            mem_wr_next   = 1'b0;
          end
        end
      end

      ISSUE: begin
        state_next = RESP;
      end

      RESP: begin
        // Without mem_complete everything is held, giving wait states.
        if (mem_complete) begin
          state_next  = IDLE;
          lg_next     = sel_reg;
          mem_rd_next = 1'b0;
          mem_wr_next = 1'b0;
          if (sel_reg) begin
            complete_data_next = 1'b1;
            if (!mem_wr_reg) begin
              data_dout_next = mem_dout;
            end
          end else begin
            complete_instr_next = 1'b1;
            instr_dout_next     = mem_dout;
          end
        end
      end

      default: begin
        state_next  = IDLE;
        mem_rd_next = 1'b0;
        mem_wr_next = 1'b0;
      end
    endcase
  end

  // State and output registers; reset abandons any access in flight.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_reg          <= IDLE;
      sel_reg            <= 1'b0;
      lg_reg             <= 1'b1;
      mem_addr_reg       <= '0;
      mem_din_reg        <= '0;
      mem_rd_reg         <= 1'b0;
      mem_wr_reg         <= 1'b0;
      instr_dout_reg     <= '0;
      data_dout_reg      <= '0;
      complete_instr_reg <= 1'b0;
      complete_data_reg  <= 1'b0;
    end else begin
      state_reg          <= state_next;
      sel_reg            <= sel_next;
      lg_reg             <= lg_next;
      mem_addr_reg       <= mem_addr_next;
      mem_din_reg        <= mem_din_next;
      mem_rd_reg         <= mem_rd_next;
      mem_wr_reg         <= mem_wr_next;
      instr_dout_reg     <= instr_dout_next;
      data_dout_reg      <= data_dout_next;
      complete_instr_reg <= complete_instr_next;
      complete_data_reg  <= complete_data_next;
    end
  end

  assign mem_addr       = mem_addr_reg;
  assign mem_din        = mem_din_reg;
  assign mem_rd         = mem_rd_reg;
  assign mem_wr         = mem_wr_reg;
  assign Instr_dout     = instr_dout_reg;
  assign Data_dout      = data_dout_reg;
  assign complete_instr = complete_instr_reg;
  assign complete_data  = complete_data_reg;
  assign busy           = (state_reg != IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter with a scoreboard of expected
// completions (port + returned data) and a simple synchronous memory model.
module tb_mem_arbiter;

  logic        clock = 1'b0;
  logic        reset;
  logic        instr_rd;
  logic [15:0] pc;
  logic [15:0] Instr_dout;
  logic        complete_instr;
  logic        Data_rd;
  logic        Data_wr;
  logic [15:0] Data_addr;
  logic [15:0] Data_din;
  logic [15:0] Data_dout;
  logic        complete_data;
  logic [15:0] mem_addr;
  logic [15:0] mem_din;
  logic        mem_rd;
  logic        mem_wr;
  logic [15:0] mem_dout;
  logic        mem_complete;
  logic        busy;

  mem_arbiter #(.ADDR_W(16), .DATA_W(16)) dut (
    .clock          (clock),
    .reset          (reset),
    .instr_rd       (instr_rd),
    .pc             (pc),
    .Instr_dout     (Instr_dout),
    .complete_instr (complete_instr),
    .Data_rd        (Data_rd),
    .Data_wr        (Data_wr),
    .Data_addr      (Data_addr),
    .Data_din       (Data_din),
    .Data_dout      (Data_dout),
    .complete_data  (complete_data),
    .mem_addr       (mem_addr),
    .mem_din        (mem_din),
    .mem_rd         (mem_rd),
    .mem_wr         (mem_wr),
    .mem_dout       (mem_dout),
    .mem_complete   (mem_complete),
    .busy           (busy)
  );

  always #5 clock = ~clock;

  // Memory model: read data valid the cycle after mem_rd is sampled.
  logic [15:0] mem [0:65535];
  always @(posedge clock) begin
    if (mem_wr) mem[mem_addr] = mem_din;
    if (mem_rd) mem_dout <= mem[mem_addr];
  end

  typedef struct {
    bit          port;   // 0 = instr, 1 = data
    logic [15:0] data;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Completion monitor: pops the scoreboard on every completion pulse.
  always @(negedge clock) begin
    if (reset === 1'b1) begin
      if (complete_instr && complete_data) check("both_complete", 1, 0);
      if (complete_instr || complete_data) begin
        if (sb.size() == 0) begin
          check("unexpected_complete", 1, 0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("port", {31'd0, complete_data}, {31'd0, e.port});
          check("dout", complete_data ? {16'd0, Data_dout} : {16'd0, Instr_dout}, {16'd0, e.data});
          $display("completion port=%0d data=0x%04h", complete_data, complete_data ? Data_dout : Instr_dout);
        end
      end
    end
  end

  // Waits for the current request to complete, releasing mem_complete after
  // w wait-state cycles in RESP; drops all requests on the completion cycle.
  task automatic wait_done(input int w, input int exp_lat, input logic [15:0] exp_addr);
    int n;
    bit done;
    n = 0;
    done = 0;
    mem_complete = (w == 0);
    while (!done && n < 64) begin
      @(negedge clock);
      n++;
      if (complete_instr || complete_data) begin
        done     = 1;
        instr_rd = 1'b0;
        Data_rd  = 1'b0;
        Data_wr  = 1'b0;
      end else begin
        if (w > 0 && n >= 2) begin
          check("wait_addr", {16'd0, mem_addr}, {16'd0, exp_addr});
          check("wait_rd", {31'd0, mem_rd}, 32'd1);
        end
        if (n == 2 + w) mem_complete = 1'b1;
      end
    end
    check("done_in_time", {31'd0, done}, 32'd1);
    check("latency", n, exp_lat);
  endtask

  task automatic push_exp(input bit port, input logic [15:0] data);
    exp_t e;
    e.port = port;
    e.data = data;
    sb.push_back(e);
  endtask

  task automatic data_access(input bit rd, input bit wr, input logic [15:0] addr,
                             input logic [15:0] din, input logic [15:0] exp_dout,
                             input int w);
    push_exp(1'b1, exp_dout);
    @(negedge clock);
    Data_rd   = rd;
    Data_wr   = wr;
    Data_addr = addr;
    Data_din  = din;
    wait_done(w, 3 + w, addr);
  endtask

  initial begin
    int cnt;
    int cyc;

    reset = 1'b0;
    instr_rd = 1'b0; pc = 16'h0;
    Data_rd = 1'b0; Data_wr = 1'b0; Data_addr = 16'h0; Data_din = 16'h0;
    mem_complete = 1'b1;
    mem[16'h3000] = 16'h1234;
    mem[16'h4000] = 16'h0000;
    mem[16'h5000] = 16'hA5A5;
    mem[16'h6000] = 16'h5A5A;

    // Reset state
    repeat (2) @(negedge clock);
    check("rst_busy", {31'd0, busy}, 0);
    check("rst_mem_rd", {31'd0, mem_rd}, 0);
    check("rst_mem_wr", {31'd0, mem_wr}, 0);
    check("rst_mem_addr", {16'd0, mem_addr}, 0);
    check("rst_instr_dout", {16'd0, Instr_dout}, 0);
    check("rst_complete", {30'd0, complete_instr, complete_data}, 0);

    // Single fetch, request present at the first edge after reset release
    push_exp(1'b0, 16'h1234);
    instr_rd = 1'b1;
    pc = 16'h3000;
    reset = 1'b1;
    $display("txn fetch pc=3000");
    wait_done(0, 3, 16'h3000);

    // Write then read
    $display("txn write addr=4000 din=beef");
    data_access(1'b0, 1'b1, 16'h4000, 16'hBEEF, 16'h0000, 0);
    check("mem_after_write", {16'd0, mem[16'h4000]}, 32'hBEEF);
    $display("txn read addr=4000");
    data_access(1'b1, 1'b0, 16'h4000, 16'h0, 16'hBEEF, 0);

    // Read with four wait states
    $display("txn read addr=3000 with 4 wait states");
    data_access(1'b1, 1'b0, 16'h3000, 16'h0, 16'h1234, 4);

    // Read and write together -> serviced as a read
    $display("txn rd+wr addr=4000 din=1111");
    push_exp(1'b1, 16'hBEEF);
    @(negedge clock);
    Data_rd = 1'b1; Data_wr = 1'b1; Data_addr = 16'h4000; Data_din = 16'h1111;
    mem_complete = 1'b1;
    @(negedge clock);
    check("rdwr_mem_rd", {31'd0, mem_rd}, 1);
    check("rdwr_mem_wr", {31'd0, mem_wr}, 0);
    wait_done(0, 2, 16'h4000);
    check("rdwr_mem_unchanged", {16'd0, mem[16'h4000]}, 32'hBEEF);

    // Reset in the middle of an access
    $display("txn reset during RESP");
    @(negedge clock);
    Data_rd = 1'b1; Data_addr = 16'h3000; mem_complete = 1'b0;
    repeat (2) @(negedge clock);
    check("mid_busy", {31'd0, busy}, 1);
    reset = 1'b0;
    #1;
    check("mid_rst_busy", {31'd0, busy}, 0);
    check("mid_rst_mem_rd", {31'd0, mem_rd}, 0);
    check("mid_rst_mem_addr", {16'd0, mem_addr}, 0);
    check("mid_rst_dout", {Instr_dout, Data_dout}, 0);
    Data_rd = 1'b0;
    mem_complete = 1'b1;
    @(negedge clock);
    reset = 1'b1;
    repeat (5) begin
      @(negedge clock);
      check("post_rst_no_complete", {30'd0, complete_instr, complete_data}, 0);
    end

    // Contention: both ports request continuously
`ifdef ARB_ROUND_ROBIN_EN
    push_exp(1'b0, 16'hA5A5);
    push_exp(1'b1, 16'h5A5A);
    push_exp(1'b0, 16'hA5A5);
    push_exp(1'b1, 16'h5A5A);
`else
    repeat (4) push_exp(1'b1, 16'h5A5A);
`endif
    $display("txn contention pc=5000 data_addr=6000");
    @(negedge clock);
    instr_rd = 1'b1; pc = 16'h5000;
    Data_rd = 1'b1; Data_addr = 16'h6000;
    cnt = 0;
    cyc = 0;
    while (cnt < 4 && cyc < 80) begin
      @(negedge clock);
      cyc++;
      if (complete_instr || complete_data) cnt++;
      if (cnt == 4) begin
        instr_rd = 1'b0;
        Data_rd = 1'b0;
      end
    end
    instr_rd = 1'b0;
    Data_rd = 1'b0;
    check("contention_count", cnt, 4);

    // Plain data read afterwards
    $display("txn read addr=6000");
    data_access(1'b1, 1'b0, 16'h6000, 16'h0, 16'h5A5A, 0);

    repeat (3) @(negedge clock);
    check("scoreboard_empty", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter: ADDR_W, default 16, width of all address buses.
REQ-002 Parameter: DATA_W, default 16, width of all data buses.
REQ-003 clock  input  1  single clock; all state updates on posedge clock.
REQ-004 reset  input  1  asynchronous, active-low reset (reset=0 resets).
REQ-005 instr_rd  input  1  instruction-fetch read request, held until complete_instr.
REQ-006 pc  input  ADDR_W  instruction-fetch address.
REQ-007 Instr_dout  output  DATA_W  registered fetch data.
REQ-008 complete_instr  output  1  one-cycle fetch completion pulse.
REQ-009 Data_rd  input  1  data read request, held until complete_data.
REQ-010 Data_wr  input  1  data write request, held until complete_data.
REQ-011 Data_addr  input  ADDR_W  data access address.
REQ-012 Data_din  input  DATA_W  write data.
REQ-013 Data_dout  output  DATA_W  registered read data.
REQ-014 complete_data  output  1  one-cycle data completion pulse.
REQ-015 mem_addr  output  ADDR_W  shared memory address.
REQ-016 mem_din  output  DATA_W  shared memory write data.
REQ-017 mem_rd  output  1  shared memory read strobe.
REQ-018 mem_wr  output  1  shared memory write strobe.
REQ-019 mem_dout  input  DATA_W  shared memory read data, valid the cycle after mem_rd is sampled.
REQ-020 mem_complete  input  1  memory ready; sampled in RESP only.
REQ-021 busy  output  1  high in any state other than IDLE.

Function
REQ-022 FSM states: IDLE, ISSUE, RESP; owner register sel (0=instr, 1=data); last-grant register lg.
REQ-023 IDLE: no request -> stay; any request -> ISSUE, sel latched per REQ-028/029.
REQ-024 ISSUE: drive mem_addr/mem_din/mem_rd/mem_wr from owner -> RESP next edge.
REQ-025 RESP: mem_complete=1 -> latch mem_dout to owner's dout (reads only), pulse owner's complete for one cycle, update lg=sel, -> IDLE.
REQ-026 RESP: mem_complete=0 -> hold all mem_* outputs unchanged, stay in RESP.
REQ-027 Latency: request sampled at edge E0 -> complete high in cycle after E2 (3-cycle minimum per access, no back-to-back overlap).
REQ-028 Both ports requesting in IDLE: arbitration per Configuration.
REQ-029 Single requester: granted regardless of lg.
REQ-030 Data_rd and Data_wr both high: treated as read; mem_wr low.
REQ-031 Writes: Data_dout unchanged; complete_data still pulses.
REQ-032 mem_rd/mem_wr low in IDLE; mem_addr/mem_din hold last values in IDLE.
REQ-033 Request withdrawn mid-access: access completes normally; completion still pulses.
REQ-034 complete_instr and complete_data never high in the same cycle.

Reset
REQ-035 reset=0 asynchronously: state=IDLE, sel=0, lg=1, mem_rd=mem_wr=0, mem_addr=mem_din=0, Instr_dout=Data_dout=0, complete_instr=complete_data=0, busy=0.
REQ-036 Reset mid-access abandons the access; no completion pulse after reset release.
REQ-037 First request after reset release is sampled at the first posedge with reset=1.

Configuration
REQ-038 Macro ARB_ROUND_ROBIN_EN defined: simultaneous requests grant the port opposite lg (instr first after reset).
REQ-039 Macro ARB_ROUND_ROBIN_EN undefined: simultaneous requests always grant data port; lg still maintained but unused.

Verification
REQ-040 Single fetch: instr_rd=1, pc=16'h3000, mem[3000]=16'h1234, mem_complete=1 -> complete_instr pulses 3 cycles after request sampled, Instr_dout=16'h1234.
REQ-041 Data write then read: Data_wr, addr 16'h4000, din 16'hBEEF; then Data_rd same addr -> Data_dout=16'hBEEF, two complete_data pulses, Data_dout unchanged after write.
REQ-042 Contention: instr_rd and Data_rd held continuously -> with ARB_ROUND_ROBIN_EN grants alternate I,D,I,D; without it data granted every access, no instr completion.
REQ-043 Wait states: mem_complete=0 for 4 cycles in RESP -> mem_addr/mem_rd stable, completion delayed exactly 4 cycles.
REQ-044 Reset mid-access: assert reset in RESP -> all outputs zero immediately, no completion pulse after release, next request served normally.
REQ-045 Rd+wr together: Data_rd=Data_wr=1 -> mem_rd=1, mem_wr=0, memory contents unchanged.
